// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS-DLX pipeline registers (IF/ID, ID/EX, EX/MEM).
// Holds default widths, the NOP encoding, the entry layout and the occupancy state encoding.
package mips_pipe_pkg;

  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_PC_W    = 10;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic                   valid;
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_PC_W-1:0]    pc1;
  } pipe_entry_t;

  // Occupancy of a two-entry skid register, derived from the valid bits.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  function automatic logic [1:0] occ_state(input logic main_v, input logic skid_v);
    if (skid_v) return ST_TWO;
    if (main_v) return ST_ONE;
    return ST_EMPTY;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch/decode handshake bundle for the IF/ID pipeline register.
// The slave modport is the register's view; the master modport drives fetch and decode stall.
interface if_id_pipe_reg_if #(
  parameter int unsigned INSTR_W = mips_pipe_pkg::DEF_INSTR_W,
  parameter int unsigned PC_W    = mips_pipe_pkg::DEF_PC_W
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc1;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc1;

  modport master (
    output in_valid, in_instr, in_pc1, out_ready,
    input  in_ready, out_valid, out_instr, out_pc1
  );

  modport slave (
    input  in_valid, in_instr, in_pc1, out_ready,
    output in_ready, out_valid, out_instr, out_pc1
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// One clocked {valid, data} pipeline entry with load and clear; clear wins over load.
module pipe_entry_reg #(
  parameter int unsigned W = 42
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID two-entry skid register (main + skid) with valid/ready handshake and flush.
// Optional IF_ID_PERF_CNT_EN adds saturating stall_cycles / flush_count outputs.
module if_id_pipe_reg #(
  parameter int unsigned        INSTR_W   = mips_pipe_pkg::DEF_INSTR_W,
  parameter int unsigned        PC_W      = mips_pipe_pkg::DEF_PC_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(mips_pipe_pkg::NOP_INSTR_DEFAULT)
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  if_id_pipe_reg_if.slave bus
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);
  import mips_pipe_pkg::*;

  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  logic               main_v, skid_v;
  logic [ENTRY_W-1:0] main_data, skid_data, in_data, main_src;
  logic               main_load, main_clear, skid_load, skid_clear;
  logic               in_ready_q, in_ready_d;
  logic               accept, consume;
  logic [1:0]         state;

  assign in_data = {bus.in_instr, bus.in_pc1};
  assign accept  = bus.in_valid & in_ready_q;
  assign consume = main_v & bus.out_ready;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_src   = in_data;
    state      = occ_state(main_v, skid_v);
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          if (accept && consume)  main_load  = 1'b1;
          else if (accept)        skid_load  = 1'b1;
          else if (consume)       main_clear = 1'b1;
        end
        ST_TWO: begin
          // in_ready is low here, so only the skid-to-main move is possible
          if (consume) begin
            main_load  = 1'b1;
            main_src   = skid_data;
            skid_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
    in_ready_d = !(skid_load || (skid_v && !skid_clear));
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_src),
    .valid     (main_v),
    .data      (main_data)
  );

  pipe_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_data (in_data),
    .valid     (skid_v),
    .data      (skid_data)
  );

  always_ff @(posedge clk) begin
    if (reset) in_ready_q <= 1'b0;
    else       in_ready_q <= in_ready_d;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_v;
  assign bus.out_instr = main_v ? main_data[ENTRY_W-1:PC_W] : NOP_INSTR;
  assign bus.out_pc1   = main_v ? main_data[PC_W-1:0] : '0;

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (main_v && !bus.out_ready && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush && flush_count_q != 16'hFFFF)
      flush_count_d = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: a scoreboard queue of expected consumed entries
// plus direct state checks. Build with +define+IF_ID_PERF_CNT_EN to cover the counters.
module tb_if_id_pipe_reg;
  logic clk = 1'b0;
  logic reset;
  logic flush;

  always #5 clk = ~clk;

  if_id_pipe_reg_if #(.INSTR_W(32), .PC_W(10)) bus ();

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  if_id_pipe_reg #(.INSTR_W(32), .PC_W(10), .NOP_INSTR(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [9:0]  pc1;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [9:0] pc1);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc1   = pc1;
  endtask

  task automatic expect_item(input logic [31:0] instr, input logic [9:0] pc1);
    exp_t e;
    e.instr = instr;
    e.pc1   = pc1;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.out_valid && bus.out_ready) begin
        $display("consume instr=%h pc1=%0d", bus.out_instr, bus.out_pc1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got instr=%h pc1=%0d, required no output",
                   bus.out_instr, bus.out_pc1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", bus.out_instr, e.instr);
          chk("sb_pc1", 32'(bus.out_pc1), 32'(e.pc1));
        end
      end
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] instr,
                         input logic [9:0] pc1, input logic rdy);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(v));
    chk({tag, "_out_instr"}, bus.out_instr, instr);
    chk({tag, "_out_pc1"}, 32'(bus.out_pc1), 32'(pc1));
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  initial begin
    reset         = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    fork
      monitor();
    join_none

    // reset for three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("reset", 1'b0, 32'h0, 10'd0, 1'b0);
    end
    reset = 1'b0;
    step();
    chk_out("release", 1'b0, 32'h0, 10'd0, 1'b1);

    // streaming with decode always ready
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h2001_0005, 10'd1);
    expect_item(32'h2001_0005, 10'd1);
    step();
    chk_out("stream1", 1'b1, 32'h2001_0005, 10'd1, 1'b1);
    drive(1'b1, 32'h2002_0006, 10'd2);
    expect_item(32'h2002_0006, 10'd2);
    step();
    chk_out("stream2", 1'b1, 32'h2002_0006, 10'd2, 1'b1);
    drive(1'b0, 32'h0, 10'd0);
    step();
    chk_out("stream_empty", 1'b0, 32'h0, 10'd0, 1'b1);

    // stall: A then B fill both entries; a third offer D is refused
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2003_0007, 10'd3);
    expect_item(32'h2003_0007, 10'd3);
    step();
    chk_out("stall_one", 1'b1, 32'h2003_0007, 10'd3, 1'b1);
    drive(1'b1, 32'h2004_0008, 10'd4);
    expect_item(32'h2004_0008, 10'd4);
    step();
    chk_out("stall_two", 1'b1, 32'h2003_0007, 10'd3, 1'b0);
    drive(1'b1, 32'hDEAD_BEEF, 10'd99);
    step();
    chk_out("stall_hold", 1'b1, 32'h2003_0007, 10'd3, 1'b0);
    drive(1'b0, 32'h0, 10'd0);
    bus.out_ready = 1'b1;
    step();
    chk_out("drain_b", 1'b1, 32'h2004_0008, 10'd4, 1'b1);
    step();
    chk_out("drain_empty", 1'b0, 32'h0, 10'd0, 1'b1);

    // flush in TWO with C presented: everything becomes a bubble
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2005_0009, 10'd5);
    step();
    drive(1'b1, 32'h2006_000A, 10'd6);
    step();
    chk("flush_pre_ready", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h2007_000B, 10'd7);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 10'd0);
    chk_out("flush", 1'b0, 32'h0, 10'd0, 1'b1);
    bus.out_ready = 1'b1;
    step();
    step();
    chk_out("flush_after", 1'b0, 32'h0, 10'd0, 1'b1);

    // reset and flush together while in ONE
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h2008_000C, 10'd8);
    step();
    chk_out("rf_one", 1'b1, 32'h2008_000C, 10'd8, 1'b1);
    drive(1'b0, 32'h0, 10'd0);
    reset = 1'b1;
    flush = 1'b1;
    step();
    chk_out("rf_reset1", 1'b0, 32'h0, 10'd0, 1'b0);
    step();
    chk_out("rf_reset2", 1'b0, 32'h0, 10'd0, 1'b0);
    reset = 1'b0;
    flush = 1'b0;
    step();
    chk_out("rf_release", 1'b0, 32'h0, 10'd0, 1'b1);

`ifdef IF_ID_PERF_CNT_EN
    chk("perf_reset_stall", 32'(stall_cycles), 32'd0);
    chk("perf_reset_flush", 32'(flush_count), 32'd0);
    drive(1'b1, 32'h2009_000D, 10'd9);
    step();
    drive(1'b0, 32'h0, 10'd0);
    repeat (5) step();
    chk("perf_stall5", 32'(stall_cycles), 32'd5);
    // first flush edge also consumes the held entry
    expect_item(32'h2009_000D, 10'd9);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    step();
    step();
    flush = 1'b0;
    chk("perf_stall_after_flush", 32'(stall_cycles), 32'd5);
    chk("perf_flush2", 32'(flush_count), 32'd2);
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h200A_000E, 10'd10);
    step();
    drive(1'b0, 32'h0, 10'd0);
    repeat (65530) step();
    chk("perf_stall_max", 32'(stall_cycles), 32'h0000_FFFF);
    repeat (3) step();
    chk("perf_stall_sat", 32'(stall_cycles), 32'h0000_FFFF);
    expect_item(32'h200A_000E, 10'd10);
    bus.out_ready = 1'b1;
    step();
    chk("perf_sat_drain_valid", 32'(bus.out_valid), 32'd0);
`endif

    step();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
